sprite_engine: RTL and testbench



---
 rtl/sprite_pkg.sv | 34 +++
 rtl/sprite_engine_if.sv | 40 ++++
 rtl/btn_sync.sv | 24 ++
 rtl/sprite_engine.sv | 176 +++++++++++++++++
 tb/tb_sprite_engine.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared types for the sprite engine: per-object state, move request
// encoding and the span test used by the renderer.
package sprite_pkg;

  typedef logic [11:0] color_t;
  typedef logic [9:0]  xpos_t;
  typedef logic [8:0]  ypos_t;
  typedef logic [7:0]  size_t;

  typedef struct packed {
    xpos_t  x;
    ypos_t  y;
    size_t  size;
    color_t color;
  } obj_t;

  typedef enum logic [2:0] {
    MV_NONE,
    MV_UP,
    MV_DOWN,
    MV_RIGHT,
    MV_LEFT,
    MV_HOME
  } move_e;

  localparam int OBJ_SPACING = 32;

  // pos <= p < pos+len, evaluated on 11 bits so the sum cannot wrap
  function automatic logic in_span(input logic [10:0] pos, input logic [10:0] len,
                                   input logic [10:0] p);
    return (p >= pos) && (p < pos + len);
  endfunction

endpackage

// File: rtl/sprite_engine_if.sv
// Board-side bundle of the sprite engine: buttons, object select,
// config write port, VGA pixel coordinate in and rendered pixel out.
interface sprite_engine_if #(
  parameter int NUM_OBJ = 4,
  parameter int SIZE_W  = 5
);
  import sprite_pkg::*;

  localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

  logic             btn_up;
  logic             btn_down;
  logic             btn_left;
  logic             btn_right;
  logic             btn_center;
  logic [IDX_W-1:0] sel;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [SIZE_W-1:0] cfg_size;
  color_t           cfg_color;
  xpos_t            horizontal;
  ypos_t            vertical;
  color_t           pix_color;
  logic             pix_hit;
  logic [IDX_W-1:0] hit_idx;
  logic             move_tick;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_center, sel,
           cfg_we, cfg_idx, cfg_size, cfg_color, horizontal, vertical,
    input  pix_color, pix_hit, hit_idx, move_tick
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_center, sel,
           cfg_we, cfg_idx, cfg_size, cfg_color, horizontal, vertical,
    output pix_color, pix_hit, hit_idx, move_tick
  );

endinterface

// File: rtl/btn_sync.sv
// Two-flop synchroniser for one raw push-button input.
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sprite_engine.sv
// Multi-object sprite controller: button-driven movement of the selected
// object on a tick, size/colour config writes and a 2-stage pixel renderer.
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int     WIDTH    = 640,
  parameter int     HEIGHT   = 480,
  parameter int     NUM_OBJ  = 4,
  parameter int     SIZE_W   = 5,
  parameter int     DEF_SIZE = 15,
  parameter int     MOVE_DIV = 65536,
  parameter bit     WRAP     = 1'b0,
  parameter color_t BG_COLOR = 12'h000
) (
  input logic            clk_100MHz,
  input logic            CPU_RESETN,
  sprite_engine_if.slave bus
);

  localparam int          IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int          CNT_W = $clog2(MOVE_DIV);
  localparam logic [10:0] W11   = 11'(WIDTH);
  localparam logic [10:0] H11   = 11'(HEIGHT);

  logic [4:0] btn_raw;
  logic [4:0] btn_s;

  assign btn_raw = {bus.btn_center, bus.btn_up, bus.btn_down, bus.btn_right, bus.btn_left};

  btn_sync u_sync [4:0] (
    .clk   (clk_100MHz),
    .rst_n (CPU_RESETN),
    .d_i   (btn_raw),
    .q_o   (btn_s)
  );

  move_e dir;

  always_comb begin
    if      (btn_s[4]) dir = MV_HOME;
    else if (btn_s[3]) dir = MV_UP;
    else if (btn_s[2]) dir = MV_DOWN;
    else if (btn_s[1]) dir = MV_RIGHT;
    else if (btn_s[0]) dir = MV_LEFT;
    else               dir = MV_NONE;
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_q;

  assign cnt_d = (cnt_q == CNT_W'(MOVE_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);

  obj_t        obj_q [NUM_OBJ];
  obj_t        obj_d [NUM_OBJ];
  obj_t        cur;
  obj_t        wr;
  logic [10:0] lim_x;
  logic [10:0] lim_y;
  logic [10:0] wlim_x;
  logic [10:0] wlim_y;

  always_comb begin
    obj_d  = obj_q;
    cur    = '0;
    wr     = '0;
    lim_x  = W11;
    lim_y  = H11;
    wlim_x = W11;
    wlim_y = H11;
    if (tick_q && (int'(bus.sel) < NUM_OBJ)) begin
      cur   = obj_q[bus.sel];
      lim_x = W11 - 11'(cur.size);
      lim_y = H11 - 11'(cur.size);
      case (dir)
        MV_HOME: begin
          cur.x = xpos_t'(OBJ_SPACING * int'(bus.sel));
          cur.y = '0;
        end
        MV_UP:    if (cur.y != '0)          cur.y = cur.y - ypos_t'(1);
                  else if (WRAP)            cur.y = ypos_t'(lim_y);
        MV_DOWN:  if (11'(cur.y) < lim_y)   cur.y = cur.y + ypos_t'(1);
                  else if (WRAP)            cur.y = '0;
        MV_RIGHT: if (11'(cur.x) < lim_x)   cur.x = cur.x + xpos_t'(1);
                  else if (WRAP)            cur.x = '0;
        MV_LEFT:  if (cur.x != '0)          cur.x = cur.x - xpos_t'(1);
                  else if (WRAP)            cur.x = xpos_t'(lim_x);
        default: ;
      endcase
      obj_d[bus.sel] = cur;
    end
    // Built from obj_q, so a write to the object being moved replaces the move.
    if (bus.cfg_we && (int'(bus.cfg_idx) < NUM_OBJ)) begin
      wr       = obj_q[bus.cfg_idx];
      wr.size  = size_t'(bus.cfg_size);
      wr.color = bus.cfg_color;
      wlim_x   = W11 - 11'(wr.size);
      wlim_y   = H11 - 11'(wr.size);
      if (11'(wr.x) > wlim_x) wr.x = xpos_t'(wlim_x);
      if (11'(wr.y) > wlim_y) wr.y = ypos_t'(wlim_y);
      obj_d[bus.cfg_idx] = wr;
    end
  end

  always_ff @(posedge clk_100MHz or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        obj_q[i].x     <= xpos_t'(OBJ_SPACING * i);
        obj_q[i].y     <= '0;
        obj_q[i].size  <= size_t'(DEF_SIZE);
        obj_q[i].color <= 12'hFFF;
      end
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_q == CNT_W'(MOVE_DIV - 1));
      obj_q  <= obj_d;
    end
  end

  logic               on_screen;
  logic [NUM_OBJ-1:0] hit_d;
  logic [NUM_OBJ-1:0] hit_q;
  color_t             col_q [NUM_OBJ];
  logic               win_hit;
  logic [IDX_W-1:0]   win_idx;
  color_t             pix_color_q;
  logic               pix_hit_q;
  logic [IDX_W-1:0]   hit_idx_q;

  assign on_screen = (11'(bus.horizontal) < W11) && (11'(bus.vertical) < H11);

  always_comb begin
    hit_d = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      hit_d[i] = on_screen
               && in_span(11'(obj_q[i].x), 11'(obj_q[i].size), 11'(bus.horizontal))
               && in_span(11'(obj_q[i].y), 11'(obj_q[i].size), 11'(bus.vertical));
    end
  end

  // Scan downwards so the lowest set index is the one left standing.
  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (hit_q[i]) begin
        win_hit = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk_100MHz or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      hit_q       <= '0;
      pix_color_q <= '0;
      pix_hit_q   <= 1'b0;
      hit_idx_q   <= '0;
      for (int i = 0; i < NUM_OBJ; i++) col_q[i] <= '0;
    end else begin
      hit_q       <= hit_d;
      pix_hit_q   <= win_hit;
      hit_idx_q   <= win_idx;
      pix_color_q <= win_hit ? col_q[win_idx] : BG_COLOR;
      for (int i = 0; i < NUM_OBJ; i++) col_q[i] <= obj_q[i].color;
    end
  end

  assign bus.pix_color = pix_color_q;
  assign bus.pix_hit   = pix_hit_q;
  assign bus.hit_idx   = hit_idx_q;
  assign bus.move_tick = tick_q;

endmodule

// File: tb/tb_sprite_engine.sv
// Directed bench: a clamp-mode and a wrap-mode engine share one stimulus
// stream; object positions are observed through the rendered pixel outputs.
module tb_sprite_engine;
  import sprite_pkg::*;

  localparam int B_NONE  = 0;
  localparam int B_UP    = 1;
  localparam int B_DOWN  = 2;
  localparam int B_RIGHT = 3;
  localparam int B_LEFT  = 4;
  localparam int B_HOME  = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  sprite_engine_if #(.NUM_OBJ(4), .SIZE_W(5)) bus_c ();
  sprite_engine_if #(.NUM_OBJ(4), .SIZE_W(5)) bus_w ();

  assign bus_w.btn_up     = bus_c.btn_up;
  assign bus_w.btn_down   = bus_c.btn_down;
  assign bus_w.btn_left   = bus_c.btn_left;
  assign bus_w.btn_right  = bus_c.btn_right;
  assign bus_w.btn_center = bus_c.btn_center;
  assign bus_w.sel        = bus_c.sel;
  assign bus_w.cfg_we     = bus_c.cfg_we;
  assign bus_w.cfg_idx    = bus_c.cfg_idx;
  assign bus_w.cfg_size   = bus_c.cfg_size;
  assign bus_w.cfg_color  = bus_c.cfg_color;
  assign bus_w.horizontal = bus_c.horizontal;
  assign bus_w.vertical   = bus_c.vertical;

  sprite_engine #(
    .WIDTH(640), .HEIGHT(480), .NUM_OBJ(4), .SIZE_W(5), .DEF_SIZE(15),
    .MOVE_DIV(4), .WRAP(1'b0), .BG_COLOR(12'h000)
  ) dut_c (
    .clk_100MHz (clk),
    .CPU_RESETN (rst_n),
    .bus        (bus_c)
  );

  sprite_engine #(
    .WIDTH(640), .HEIGHT(480), .NUM_OBJ(4), .SIZE_W(5), .DEF_SIZE(15),
    .MOVE_DIV(4), .WRAP(1'b1), .BG_COLOR(12'h000)
  ) dut_w (
    .clk_100MHz (clk),
    .CPU_RESETN (rst_n),
    .bus        (bus_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input bit wrap_dut, input logic hit,
                     input int idx, input color_t col);
    if (wrap_dut) begin
      check({tag, ".w.hit"}, 32'(bus_w.pix_hit),   32'(hit));
      check({tag, ".w.idx"}, 32'(bus_w.hit_idx),   32'(idx));
      check({tag, ".w.col"}, 32'(bus_w.pix_color), 32'(col));
    end else begin
      check({tag, ".c.hit"}, 32'(bus_c.pix_hit),   32'(hit));
      check({tag, ".c.idx"}, 32'(bus_c.hit_idx),   32'(idx));
      check({tag, ".c.col"}, 32'(bus_c.pix_color), 32'(col));
    end
  endtask

  task automatic look(input int h, input int v);
    bus_c.horizontal = xpos_t'(h);
    bus_c.vertical   = ypos_t'(v);
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input int b);
    bus_c.btn_up     = (b == B_UP);
    bus_c.btn_down   = (b == B_DOWN);
    bus_c.btn_right  = (b == B_RIGHT);
    bus_c.btn_left   = (b == B_LEFT);
    bus_c.btn_center = (b == B_HOME);
  endtask

  task automatic run_ticks(input int n);
    int cnt;
    int guard;
    cnt   = 0;
    guard = 0;
    while (cnt < n && guard < 5000) begin
      if (bus_c.move_tick) cnt++;
      if (cnt < n) begin
        @(negedge clk);
        guard++;
      end
    end
    check("tick_budget", 32'(cnt), 32'(n));
  endtask

  task automatic move(input int s, input int b, input int n);
    bus_c.sel = 2'(s);
    press(b);
    repeat (2) @(negedge clk);
    run_ticks(n);
    press(B_NONE);
    @(negedge clk);
  endtask

  task automatic cfg(input int idx, input int size, input color_t col);
    bus_c.cfg_idx   = 2'(idx);
    bus_c.cfg_size  = 5'(size);
    bus_c.cfg_color = col;
    bus_c.cfg_we    = 1'b1;
    @(negedge clk);
    bus_c.cfg_we    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    press(B_NONE);
    bus_c.sel        = '0;
    bus_c.cfg_we     = 1'b0;
    bus_c.cfg_idx    = '0;
    bus_c.cfg_size   = '0;
    bus_c.cfg_color  = '0;
    bus_c.horizontal = xpos_t'(700);
    bus_c.vertical   = '0;
    repeat (3) @(negedge clk);
    chk("rst", 1'b0, 1'b0, 0, 12'h000);
    chk("rst", 1'b1, 1'b0, 0, 12'h000);
    check("rst.tick", 32'(bus_c.move_tick), 32'd0);

    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("tick_phase", 32'(bus_c.move_tick), 32'((i % 4) == 0));
    end

    look(32, 0);   chk("home1", 1'b0, 1'b1, 1, 12'hFFF);
    look(47, 0);   chk("home1_edge", 1'b0, 1'b0, 0, 12'h000);
    look(110, 14); chk("home3", 1'b0, 1'b1, 3, 12'hFFF);

    // obj0 ten steps right
    move(0, B_RIGHT, 10);
    look(10, 0);   chk("r10_left", 1'b0, 1'b1, 0, 12'hFFF);
                   chk("r10_left", 1'b1, 1'b1, 0, 12'hFFF);
    look(9, 0);    chk("r10_before", 1'b0, 1'b0, 0, 12'h000);
    look(24, 0);   chk("r10_right", 1'b0, 1'b1, 0, 12'hFFF);
    look(25, 0);   chk("r10_after", 1'b0, 1'b0, 0, 12'h000);
    look(32, 0);   chk("r10_obj1", 1'b0, 1'b1, 1, 12'hFFF);

    // obj1 to the right edge and beyond, then up at the top edge
    move(1, B_RIGHT, 596);
    look(625, 0);  chk("clamp_r", 1'b0, 1'b1, 1, 12'hFFF);
    look(624, 0);  chk("clamp_r_out", 1'b0, 1'b0, 0, 12'h000);
    look(639, 14); chk("clamp_r_far", 1'b0, 1'b1, 1, 12'hFFF);
    move(1, B_UP, 3);
    look(625, 0);  chk("clamp_u", 1'b0, 1'b1, 1, 12'hFFF);
    look(625, 15); chk("clamp_u_out", 1'b0, 1'b0, 0, 12'h000);

    // wrap vs clamp at the left/top/bottom edges
    move(1, B_HOME, 1);
    move(0, B_HOME, 1);
    move(0, B_LEFT, 1);
    look(0, 0);    chk("left0", 1'b0, 1'b1, 0, 12'hFFF);
                   chk("left0", 1'b1, 1'b0, 0, 12'h000);
    look(625, 0);  chk("left625", 1'b0, 1'b0, 0, 12'h000);
                   chk("left625", 1'b1, 1'b1, 0, 12'hFFF);
    move(0, B_UP, 1);
    look(625, 465); chk("up465", 1'b1, 1'b1, 0, 12'hFFF);
                    chk("up465", 1'b0, 1'b0, 0, 12'h000);
    look(625, 464); chk("up464", 1'b1, 1'b0, 0, 12'h000);
    move(0, B_DOWN, 1);
    look(625, 0);  chk("down_wrap", 1'b1, 1'b1, 0, 12'hFFF);
    look(0, 0);    chk("down_clamp0", 1'b0, 1'b0, 0, 12'h000);
    look(0, 15);   chk("down_clamp15", 1'b0, 1'b1, 0, 12'hFFF);

    // overlap priority
    move(0, B_HOME, 1);
    move(1, B_LEFT, 27);
    move(1, B_DOWN, 5);
    cfg(1, 15, 12'hF00);
    @(negedge clk);
    look(6, 6);    chk("ovl_both", 1'b0, 1'b1, 0, 12'hFFF);
    look(16, 16);  chk("ovl_obj1", 1'b0, 1'b1, 1, 12'hF00);
                   chk("ovl_obj1", 1'b1, 1'b1, 1, 12'hF00);
    look(19, 19);  chk("ovl_corner", 1'b0, 1'b1, 1, 12'hF00);
    look(20, 20);  chk("ovl_out", 1'b0, 1'b0, 0, 12'h000);
    look(700, 6);  chk("offscreen_h", 1'b0, 1'b0, 0, 12'h000);
    look(6, 480);  chk("offscreen_v", 1'b0, 1'b0, 0, 12'h000);

    // config write to obj1 on the very tick that would move it left
    bus_c.sel = 2'd1;
    press(B_LEFT);
    repeat (2) @(negedge clk);
    run_ticks(1);
    cfg(1, 15, 12'h0F0);
    press(B_NONE);
    @(negedge clk);
    look(19, 19);  chk("wr_vs_move", 1'b0, 1'b1, 1, 12'h0F0);
    look(4, 18);   chk("wr_vs_move_x", 1'b0, 1'b0, 0, 12'h000);

    // resize with edge clamp while a move tick lands on the same object
    cfg(2, 5, 12'hFFF);
    bus_c.sel = 2'd2;
    press(B_RIGHT);
    repeat (2) @(negedge clk);
    run_ticks(566);
    @(negedge clk);
    run_ticks(1);
    cfg(2, 20, 12'hFFF);
    press(B_NONE);
    @(negedge clk);
    look(620, 0);  chk("resize_x", 1'b0, 1'b1, 2, 12'hFFF);
    look(619, 0);  chk("resize_before", 1'b0, 1'b0, 0, 12'h000);
    look(639, 19); chk("resize_corner", 1'b0, 1'b1, 2, 12'hFFF);
    look(639, 20); chk("resize_below", 1'b0, 1'b0, 0, 12'h000);

    // asynchronous reset in the middle of a move
    bus_c.horizontal = xpos_t'(625);
    bus_c.vertical   = ypos_t'(10);
    bus_c.sel        = 2'd2;
    press(B_DOWN);
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 1'b0, 1'b0, 0, 12'h000);
    check("async_rst.tick", 32'(bus_c.move_tick), 32'd0);
    @(negedge clk);
    press(B_NONE);
    bus_c.horizontal = xpos_t'(32);
    bus_c.vertical   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_lat1", 32'(bus_c.pix_hit), 32'd0);
    @(negedge clk);
    chk("post_rst_lat2", 1'b0, 1'b1, 1, 12'hFFF);
    look(64, 0);   chk("post_rst_obj2", 1'b0, 1'b1, 2, 12'hFFF);
    look(79, 0);   chk("post_rst_obj2_sz", 1'b0, 1'b0, 0, 12'h000);
    look(64, 15);  chk("post_rst_obj2_y", 1'b0, 1'b0, 0, 12'h000);
    look(0, 0);    chk("post_rst_obj0", 1'b0, 1'b1, 0, 12'hFFF);
                   chk("post_rst_obj0", 1'b1, 1'b1, 0, 12'hFFF);
    look(110, 14); chk("post_rst_obj3", 1'b0, 1'b1, 3, 12'hFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
